reg_scoreboard: RTL and testbench

- Sequential register-hazard controller for the decode/register-read stage of the x86 pipeline.
- Tracks in-flight GPR writes with per-register pending counters: incremented at issue, decremented at writeback.
- Holds decode (dec_ready=0) while any source register of the decoding instruction has a pending write.
- Clears on pipeline flush.

---
 rtl/scb_pkg.sv | 30 +++
 rtl/reg_scoreboard_if.sv | 39 +++
 rtl/scb_counter.sv | 72 +++++++
 rtl/reg_scoreboard.sv | 114 +++++++++++
 tb/tb_reg_scoreboard.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scb_pkg.sv
// Shared types and ModRM helpers for the register scoreboard.
// Optional feature macro: SCB_PERF_EN (adds a stall-cycle counter to the top).
package scb_pkg;

  localparam int REG_W = 3;
  localparam int NREG  = 8;

  localparam logic [1:0] MOD_REG = 2'b11;
  localparam logic [2:0] RM_SIB  = 3'b100;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10
  } scb_state_e;

  typedef struct packed {
    logic [REG_W-1:0] idx;
    logic             we;
  } dest_t;

  // A memory-form r/m destination never writes a GPR.
  function automatic dest_t modrm_dest(input logic [7:0] modrm, input logic rmsel, input logic we);
    dest_t d;
    d.idx = rmsel ? modrm[2:0] : modrm[5:3];
    d.we  = we & (~rmsel | (modrm[7:6] == MOD_REG));
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/status bundle between the pipeline and the register scoreboard.
// Optional feature macro: SCB_PERF_EN (adds stall_cycles).
interface reg_scoreboard_if #(parameter int NREG = 8);

  logic            dec_v;
  logic [7:0]      dec_modrm;
  logic            dec_ro_needed;
  logic            dec_rm_needed;
  logic            dec_we;
  logic            dec_rmsel;
  logic            dec_ready;
  logic            wb_v;
  logic [2:0]      wb_reg;
  logic            flush;
  logic [NREG-1:0] pend_vec;
  logic            stall;
`ifdef SCB_PERF_EN
  logic [31:0]     stall_cycles;
`endif

  modport master (
    output dec_v, dec_modrm, dec_ro_needed, dec_rm_needed, dec_we, dec_rmsel,
    output wb_v, wb_reg, flush,
`ifdef SCB_PERF_EN
    input  stall_cycles,
`endif
    input  dec_ready, pend_vec, stall
  );

  modport slave (
    input  dec_v, dec_modrm, dec_ro_needed, dec_rm_needed, dec_we, dec_rmsel,
    input  wb_v, wb_reg, flush,
`ifdef SCB_PERF_EN
    output stall_cycles,
`endif
    output dec_ready, pend_vec, stall
  );

endinterface

// File: rtl/scb_counter.sv
// Single pending-write counter: saturating up/down with synchronous clear,
// plus a checker flagging a writeback against a register with nothing pending.
module scb_counter #(parameter int CNT_W = 3) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             is_max,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             nz_r;

  // Next count: clear wins, inc+dec cancel, both ends hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (inc && !dec && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (dec && !inc && (cnt_r != CNT_ZERO)) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register and its registered nonzero view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
      nz_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      nz_r  <= (cnt_nxt_s != CNT_ZERO);
    end
  end

  assign cnt     = cnt_r;
  assign is_max  = (cnt_r == CNT_MAX);
  assign nonzero = nz_r;

  scb_counter_chk #(.CNT_W(CNT_W)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (dec),
    .clr   (clr),
    .cnt   (cnt_r)
  );

endmodule

module scb_counter_chk #(parameter int CNT_W = 3) (
  input logic             clk,
  input logic             rst_n,
  input logic             dec,
  input logic             clr,
  input logic [CNT_W-1:0] cnt
);

  a_no_dec_of_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !clr && (cnt == {CNT_W{1'b0}})));

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage GPR hazard scoreboard: per-register pending-write counters gate dec_ready.
// Optional feature macro: SCB_PERF_EN (stall_cycles perf counter, cleared by rst_n only).
module reg_scoreboard #(
  parameter int NREG  = 8,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave bus
);

  import scb_pkg::*;

  logic [REG_W-1:0] ro_s;
  logic [REG_W-1:0] rm_s;
  logic             rm_isreg_s;
  logic             dep_s;
  logic             sat_s;
  logic             ready_s;
  logic             issue_s;
  logic             stall_cond_s;
  logic             stall_r;
  dest_t            dest_s;
  scb_state_e       state_r;
  scb_state_e       state_nxt_s;

  logic [NREG-1:0]  wb_hit_s;
  logic [NREG-1:0]  inc_s;
  logic [NREG-1:0]  is_max_s;
  logic [NREG-1:0]  nz_s;
  logic [NREG-1:0]  eff_nz_s;
  logic [CNT_W-1:0] cnt_s [NREG];

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign wb_hit_s[i] = bus.wb_v && (bus.wb_reg == REG_W'(i));
    assign inc_s[i]    = issue_s && dest_s.we && (dest_s.idx == REG_W'(i));
    // A same-cycle writeback of the last pending write releases the hazard.
    assign eff_nz_s[i] = (cnt_s[i] != {CNT_W{1'b0}}) &&
                         !(wb_hit_s[i] && (cnt_s[i] == {{(CNT_W-1){1'b0}}, 1'b1}));

    scb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_s[i]),
      .dec     (wb_hit_s[i]),
      .clr     (bus.flush),
      .cnt     (cnt_s[i]),
      .is_max  (is_max_s[i]),
      .nonzero (nz_s[i])
    );
  end

  // Source/destination decode and the hazard/saturation checks.
  always_comb begin
    ro_s       = bus.dec_modrm[5:3];
    rm_s       = bus.dec_modrm[2:0];
    rm_isreg_s = !((bus.dec_modrm[7:6] == 2'b00) && (rm_s == RM_SIB));
    dest_s     = modrm_dest(bus.dec_modrm, bus.dec_rmsel, bus.dec_we);
    dep_s      = (bus.dec_ro_needed && eff_nz_s[ro_s]) ||
                 (bus.dec_rm_needed && rm_isreg_s && eff_nz_s[rm_s]);
    sat_s      = dest_s.we && is_max_s[dest_s.idx] && !wb_hit_s[dest_s.idx];
    ready_s    = (state_r != FLUSH) && !dep_s && !sat_s;
    issue_s    = bus.dec_v && ready_s;
    stall_cond_s = bus.dec_v && !ready_s && (state_r != FLUSH);
  end

  // FSM next state; flush overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = FLUSH;
    end else begin
      case (state_r)
        RUN:     state_nxt_s = (bus.dec_v && !ready_s) ? HOLD : RUN;
        HOLD:    state_nxt_s = (ready_s || !bus.dec_v) ? RUN : HOLD;
        FLUSH:   state_nxt_s = RUN;
        default: state_nxt_s = RUN;
      endcase
    end
  end

  // State and stall registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      stall_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      stall_r <= stall_cond_s;
    end
  end

  assign bus.dec_ready = ready_s && rst_n;
  assign bus.pend_vec  = nz_s;
  assign bus.stall     = stall_r;

`ifdef SCB_PERF_EN
  logic [31:0] stall_cycles_r;

  // Saturating stall-cycle count; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_cond_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.stall_cycles = stall_cycles_r;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios plus randomized
// traffic, all checked each cycle against a counter-array model of the scoreboard rules.
module tb_reg_scoreboard;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREG(8)) bus();

  reg_scoreboard #(.NREG(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: pending writes per register, "in flush cycle" flag, expected stall and perf.
  int     mcnt [8];
  bit     m_infl;
  bit     m_stall;
  longint m_perf;
  bit     er;
  bit     iss;
  int     dst;
  bit     dwe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_dest();
    return bus.dec_rmsel ? int'(bus.dec_modrm[2:0]) : int'(bus.dec_modrm[5:3]);
  endfunction

  function automatic bit m_dwe();
    return bus.dec_we && (!bus.dec_rmsel || bus.dec_modrm[7:6] == 2'd3);
  endfunction

  function automatic bit m_ready();
    int ro, rm, d;
    bit isreg, dep, sat;
    int eff [8];
    if (m_infl) return 1'b0;
    ro    = int'(bus.dec_modrm[5:3]);
    rm    = int'(bus.dec_modrm[2:0]);
    isreg = !(bus.dec_modrm[7:6] == 2'd0 && rm == 4);
    d     = m_dest();
    for (int i = 0; i < 8; i++)
      eff[i] = mcnt[i] - ((bus.wb_v && int'(bus.wb_reg) == i) ? 1 : 0);
    dep = (bus.dec_ro_needed && eff[ro] != 0) || (bus.dec_rm_needed && isreg && eff[rm] != 0);
    sat = m_dwe() && mcnt[d] == 7 && !(bus.wb_v && int'(bus.wb_reg) == d);
    return !dep && !sat;
  endfunction

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (mcnt[i] != 0);
    return p;
  endfunction

  // Compare process: outputs vs model at every falling edge, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_dec_ready", {31'd0, bus.dec_ready}, 32'd0);
      chk("rst_pend_vec", {24'd0, bus.pend_vec}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      m_infl = 1'b0; m_stall = 1'b0; m_perf = 0;
    end else begin
      er = m_ready();
      chk("dec_ready", {31'd0, bus.dec_ready}, {31'd0, er});
      chk("pend_vec", {24'd0, bus.pend_vec}, {24'd0, m_pend()});
      chk("stall", {31'd0, bus.stall}, {31'd0, m_stall});
`ifdef SCB_PERF_EN
      chk("stall_cycles", bus.stall_cycles, m_perf[31:0]);
`endif
      m_stall = bus.dec_v && !er && !m_infl;
      if (m_stall && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (bus.flush) begin
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
        m_infl = 1'b1;
      end else begin
        iss = bus.dec_v && er;
        dst = m_dest();
        dwe = m_dwe();
        for (int i = 0; i < 8; i++) begin
          mcnt[i] = mcnt[i] + ((iss && dwe && dst == i) ? 1 : 0)
                            - ((bus.wb_v && int'(bus.wb_reg) == i) ? 1 : 0);
          if (mcnt[i] < 0) mcnt[i] = 0;
        end
        m_infl = 1'b0;
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] m, input bit ron, input bit rmn,
                       input bit we, input bit rmsel, input bit wbv, input logic [2:0] wbr,
                       input bit fl);
    bus.dec_v = v; bus.dec_modrm = m; bus.dec_ro_needed = ron; bus.dec_rm_needed = rmn;
    bus.dec_we = we; bus.dec_rmsel = rmsel; bus.wb_v = wbv; bus.wb_reg = wbr; bus.flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nz [$];
    bit ron, rmn, fl;
    logic [7:0] m;

    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("lit_idle_ready", {31'd0, bus.dec_ready}, 32'd1);
    chk("lit_idle_pend", {24'd0, bus.pend_vec}, 32'd0);
    chk("lit_idle_stall", {31'd0, bus.stall}, 32'd0);

    // RAW hazard on reg 1
    drive(1'b1, 8'hC8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lit_raw_issue_ready", {31'd0, bus.dec_ready}, 32'd1);
    tick();
    chk("lit_raw_pend", {24'd0, bus.pend_vec}, 32'h02);
    drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lit_raw_held", {31'd0, bus.dec_ready}, 32'd0);
    tick();
    chk("lit_raw_stall", {31'd0, bus.stall}, 32'd1);
    drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    chk("lit_raw_wb_release", {31'd0, bus.dec_ready}, 32'd1);
    tick();
    chk("lit_raw_drained", {24'd0, bus.pend_vec}, 32'h00);

    // Memory destination and SIB-form r/m source
    drive(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("lit_mem_no_dep", {31'd0, bus.dec_ready}, 32'd1);
    tick();
    chk("lit_mem_no_inc", {24'd0, bus.pend_vec}, 32'h10);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    tick();

    // Simultaneous issue and writeback on reg 3 at count 2
    repeat (2) begin
      drive(1'b1, 8'hD8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hD8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    chk("lit_simul_one_left", {24'd0, bus.pend_vec}, 32'h08);
    tick();
    chk("lit_simul_empty", {24'd0, bus.pend_vec}, 32'h00);

    // Saturation on reg 2
    repeat (7) begin
      drive(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lit_sat_held", {31'd0, bus.dec_ready}, 32'd0);
    drive(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
    chk("lit_sat_release", {31'd0, bus.dec_ready}, 32'd1);
    tick();
    repeat (7) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
      tick();
    end
    chk("lit_sat_drained", {24'd0, bus.pend_vec}, 32'h00);

    // Flush during HOLD with counters {1,3,0,...}
    drive(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    repeat (3) begin
      drive(1'b1, 8'hC8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      tick();
    end
    drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lit_fl_pend", {24'd0, bus.pend_vec}, 32'h03);
    tick();
    drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    drive(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lit_fl_cleared", {24'd0, bus.pend_vec}, 32'h00);
    chk("lit_fl_not_ready", {31'd0, bus.dec_ready}, 32'd0);
    tick();
    chk("lit_fl_run_ready", {31'd0, bus.dec_ready}, 32'd1);
    chk("lit_fl_stall", {31'd0, bus.stall}, 32'd0);
`ifdef SCB_PERF_EN
    chk("lit_perf_kept", bus.stall_cycles, 32'd3);
`endif
    tick();

    // Randomized traffic; writebacks only target registers with pending writes.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      nz.delete();
      for (int i = 0; i < 8; i++) if (mcnt[i] != 0) nz.push_back(i);
      m = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) m[7:6] = 2'b11;
      ron = ($urandom_range(0, 1) == 1);
      rmn = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 39) == 0);
      if (nz.size() != 0 && $urandom_range(0, 99) < 55)
        drive($urandom_range(0, 3) != 0, m, ron, rmn, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, 1'b1, 3'(nz[$urandom_range(0, nz.size() - 1)]), fl);
      else
        drive($urandom_range(0, 3) != 0, m, ron, rmn, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, 1'b0, 3'd0, fl);
      tick();
    end

    idle();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
